ofm_maxpool_2x2: RTL and testbench
==================================

# ofm_maxpool_2x2

Streaming 2×2, stride-2 max-pool stage that sits directly downstream of the layer-1 output-feature-map FIFO. It pulls conv/activation results from the FIFO one pixel at a time in raster order, using the FIFO's `rd_en`/`empty` interface with 1-cycle registered read data. It keeps a half-width line buffer of horizontal pair maxima and emits one pooled value per 2×2 window on a valid/ready output. One `start` pulse processes exactly one IMG_W × IMG_H channel plane.

## Interface
- `DATA_WIDTH`, 16: pixel width, signed two's complement.
- `IMG_W`, 416: input plane width in pixels. Must be even and ≥ 2.
- `IMG_H`, 416: input plane height in pixels. Must be even and ≥ 2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse that begins one plane. Accepted only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the last pooled value has left the block.
- `fifo_rd_en` out 1: read request to the OFM FIFO.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_data` in DATA_WIDTH: FIFO read data, valid the cycle after `fifo_rd_en && !fifo_empty`.
- `pool_valid` out 1: `pool_data` is valid.
- `pool_ready` in 1: downstream accepts `pool_data`.
- `pool_data` out DATA_WIDTH: pooled result.

## Operation
- FSM states:
  - IDLE: on `start`, clear `col`, `row` and the pixel count, then go to RUN.
  - RUN: stays until IMG_W·IMG_H reads have been issued and captured, then go to FLUSH.
  - FLUSH: stays until the output buffer is empty, then go to DONE.
  - DONE: asserts `done` for 1 cycle, then returns to IDLE.
- Read fire:
  - rd_fire = `fifo_rd_en && !fifo_empty`.
  - `fifo_rd_en` = RUN && issued < IMG_W·IMG_H && (obuf_cnt + outputs_in_flight < 2).
  - `fifo_rd_en` is never asserted outside RUN.
- Capture:
  - A registered flag `cap` = previous-cycle rd_fire.
  - When `cap` is high, `fifo_data` is the pixel at (`row`, `col`).
  - `col` and `row` advance on `cap`. `col` wraps from IMG_W−1 to 0, and `row` increments on that wrap.
- Horizontal pair:
  - On even `col`, store the pixel in `hold`.
  - On odd `col`, hmax = max(`hold`, pixel), using a signed compare.
- Line buffer (IMG_W/2 entries):
  - Even `row`, odd `col`: linebuf[col/2] ← hmax.
  - Odd `row`, odd `col`: result = max(linebuf[col/2], hmax), pushed into the output buffer on the next cycle.
- Output buffer:
  - 2-entry FIFO driving `pool_valid`/`pool_data`.
  - A pop occurs on `pool_valid && pool_ready`.
  - A simultaneous push and pop leaves the count unchanged.
  - It can never overflow, because of the read gating above.
- Totals per plane: IMG_W·IMG_H reads and (IMG_W/2)·(IMG_H/2) outputs, in raster order of the pooled grid.
- `start` while `busy` is ignored.
- Equal operands: either value may be forwarded, since the result is identical.

## Timing
- Reset values: `busy`=0, `done`=0, `fifo_rd_en`=0, `pool_valid`=0, `pool_data`=0. FSM in IDLE, all counters 0, `cap`=0.
- Line-buffer contents are don't-care after reset.
- Latency: rd_fire in cycle t → capture at t+1 → result registered into the output buffer at the end of t+2 → `pool_valid` high in t+3 if the buffer was empty.
- Sustained throughput: 1 read per cycle while FIFO is non-empty and `pool_ready`=1.
- Empty gaps: `fifo_empty` high stalls reads with no state change. Counters hold.
- Backpressure: `pool_data` is stable while `pool_valid && !pool_ready`. Reads stop when 2 outputs are buffered or in flight.
- `done` fires the cycle after the final output is popped.
- `rst_n` low mid-plane: immediate return to reset values. Partially read FIFO data is abandoned, and the FIFO owner clears it via `rd_clr`/`wr_clr`.

## Configuration
- `MAXPOOL_RELU_EN`:
  - Defined: a ReLU is fused after pooling. Each result is clamped to zero when negative, so the pushed value is max(result, 0).
  - Undefined: the signed pooled result is output unchanged.

## Test plan
- Nominal plane, IMG_W=IMG_H=4:
  - Stimulus: rows 1,2,3,4 / 5,6,7,8 / −1,−2,−3,−4 / −5,−6,−7,−8, FIFO always non-empty, `pool_ready`=1.
  - Required outputs without the macro: 6, 8, −1, −3.
  - Required outputs with `MAXPOOL_RELU_EN`: 6, 8, 0, 0.
  - Then `done` pulses once, and exactly 16 rd_fires occur.
- Throughput: same plane, continuous supply → 16 consecutive `fifo_rd_en` cycles, first `pool_valid` 3 cycles after the first rd_fire of row 1 col 1.
- Backpressure: `pool_ready` held 0 for 20 cycles mid-plane → at most 2 results buffered, `fifo_rd_en` deasserts, `pool_data` stable, and no value is lost or duplicated after release.
- FIFO starvation: `fifo_empty` toggled randomly → same 4 outputs in order, `fifo_rd_en` never high in IDLE or DONE.
- Reset mid-operation: assert `rst_n`=0 after 7 reads → all outputs at reset values. A new `start` on a fresh plane yields correct results.
- Control corner cases:
  - `start` pulsed while busy → ignored, and exactly one `done` per accepted `start`.
  - Signed ties such as −32768 vs −32768 → output −32768 without the macro.

Source files
------------

// File: rtl/ofm_maxpool_2x2_if.sv
// ofm_maxpool_2x2_if: OFM FIFO read port plus pooled-output valid/ready stream.
// master = pooling stage, slave = FIFO owner / downstream consumer.
interface ofm_maxpool_2x2_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  fifo_rd_en;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  pool_valid;
    logic                  pool_ready;
    logic [DATA_WIDTH-1:0] pool_data;
    modport master (
        output fifo_rd_en, pool_valid, pool_data,
        input  fifo_empty, fifo_data, pool_ready
    );
    modport slave (
        input  fifo_rd_en, pool_valid, pool_data,
        output fifo_empty, fifo_data, pool_ready
    );
endinterface

// File: rtl/ofm_maxpool_2x2.sv
// ofm_maxpool_2x2: streaming 2x2 stride-2 signed max-pool over one IMG_W x IMG_H plane per start.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module ofm_maxpool_2x2 #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 416,
    parameter int IMG_H      = 416
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    ofm_maxpool_2x2_if.master bus
);
    localparam int HB = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
    localparam int CW = HB + 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int PW = $clog2(IMG_W * IMG_H + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [PW-1:0] NPIX     = PW'(IMG_W * IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                       state;
    logic [CW-1:0]                col;
    logic [RW-1:0]                row;
    logic [PW-1:0]                issued, captured;
    logic [1:0]                   cnt;
    logic                         cap, res_v, rd_fire, push, pop, out_px;
    logic signed [DATA_WIDTH-1:0] pix, hold, hmax, lb_rd, pooled, res_d, res, ob0, ob1;
    logic signed [DATA_WIDTH-1:0] linebuf [IMG_W/2];

    assign pix    = $signed(bus.fifo_data);
    assign hmax   = (hold > pix) ? hold : pix;
    assign lb_rd  = linebuf[col[HB:1]];
    assign pooled = (lb_rd > hmax) ? lb_rd : hmax;
    assign out_px = cap && row[0] && col[0];
`ifdef MAXPOOL_RELU_EN
    assign res_d  = pooled[DATA_WIDTH-1] ? '0 : pooled;
`else
    assign res_d  = pooled;
`endif
    // The captured pixel and the one being fired can hold at most one output between them,
    // so counting only buffered and registered results keeps the 2-entry buffer from overflowing.
    assign bus.fifo_rd_en = (state == RUN) && (issued < NPIX) && (3'(cnt) + 3'(res_v) < 3'd2);
    assign rd_fire        = bus.fifo_rd_en && !bus.fifo_empty;
    assign push           = res_v;
    assign pop            = bus.pool_valid && bus.pool_ready;
    assign bus.pool_valid = cnt != 2'd0;
    assign bus.pool_data  = ob0;
    assign busy           = state != IDLE;
    assign done           = state == DONE;

    always_ff @(posedge clk)
        if (cap && !row[0] && col[0]) linebuf[col[HB:1]] <= hmax;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            issued   <= '0;
            captured <= '0;
            cap      <= 1'b0;
            res_v    <= 1'b0;
            res      <= '0;
            hold     <= '0;
            cnt      <= '0;
            ob0      <= '0;
            ob1      <= '0;
        end else begin
            cap   <= rd_fire;
            res_v <= out_px;
            if (out_px) res <= res_d;
            if (rd_fire) issued <= issued + PW'(1);
            if (cap) begin
                captured <= captured + PW'(1);
                col      <= (col == COL_LAST) ? '0 : col + CW'(1);
                if (col == COL_LAST) row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                if (!col[0]) hold <= pix;
            end
            if (pop) ob0 <= ob1;
            if (push) begin
                if (cnt - 2'(pop) == 2'd0) ob0 <= res;
                else ob1 <= res;
            end
            cnt <= cnt + 2'(push) - 2'(pop);
            case (state)
                IDLE: if (start) begin
                    state    <= RUN;
                    col      <= '0;
                    row      <= '0;
                    issued   <= '0;
                    captured <= '0;
                end
                RUN:     if (captured == NPIX) state <= FLUSH;
                FLUSH:   if (!res_v && (cnt == 2'd0 || (cnt == 2'd1 && pop))) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ofm_maxpool_2x2.sv
// tb_ofm_maxpool_2x2: table-driven 4x4 planes checked through an output scoreboard,
// plus mid-plane reset, duplicate start, starvation and backpressure sequences.
module tb_ofm_maxpool_2x2;
    localparam int DW = 16, IMG_W = 4, IMG_H = 4, NPX = IMG_W * IMG_H, NOUT = NPX / 4;

    typedef struct packed {
        logic [NPX-1:0][DW-1:0]  px;
        logic [NOUT-1:0][DW-1:0] ex;
        logic                    starve;
        logic                    bp;
        logic                    dup;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, start, busy, done;

    ofm_maxpool_2x2_if #(.DATA_WIDTH(DW)) bus();

    ofm_maxpool_2x2 #(.DATA_WIDTH(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] src[$], sb[$], pend;
    logic [DW-1:0]        prev_d;
    logic                 pend_v, prev_v, prev_r, start_next, starve, dup_pending;
    int checks, fails, cyc, fires, f0, done_cnt, done_cyc, last_pop, first_v, fire_w1, run, max_run, bp_left;
    int bp_at = 9;
    vec_t tbl[5];

    int nom[NPX]    = '{1, 2, 3, 4, 5, 6, 7, 8, -1, -2, -3, -4, -5, -6, -7, -8};
    int nom_e[NOUT] = '{6, 8, -1, -3};
    int tie[NPX]    = '{default: -32768};
    int tie_e[NOUT] = '{default: -32768};
    int ext[NPX]    = '{32767, -32768, -1, 0, -32768, -32768, 5, -5, 0, -1, -2, -3, -4, -100, 100, -32768};
    int ext_e[NOUT] = '{32767, 5, 0, 100};
    int rp[NPX], re[NOUT];

    task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic vec_t mk(input int p[NPX], input int e[NOUT], input logic s, input logic b, input logic d);
        vec_t v;
        for (int i = 0; i < NPX; i++) v.px[i] = DW'(p[i]);
        for (int i = 0; i < NOUT; i++) v.ex[i] = DW'(e[i]);
        v.starve = s;
        v.bp     = b;
        v.dup    = d;
        return v;
    endfunction

    function automatic int pool_ref(input int p[NPX], input int k);
        int base = 2 * (k / (IMG_W / 2)) * IMG_W + 2 * (k % (IMG_W / 2));
        int m = p[base];
        if (p[base + 1] > m) m = p[base + 1];
        if (p[base + IMG_W] > m) m = p[base + IMG_W];
        if (p[base + IMG_W + 1] > m) m = p[base + IMG_W + 1];
        return m;
    endfunction

    // One clock: drive FIFO/handshake inputs at the falling edge, then observe the DUT.
    task automatic tick();
        logic hold_rdy;
        @(negedge clk);
        cyc++;
        if (pend_v) bus.fifo_data = pend;
        pend_v = 1'b0;
        start = start_next;
        start_next = 1'b0;
        bus.fifo_empty = (src.size() == 0) || (starve && $urandom_range(0, 2) == 0);
        hold_rdy = bp_left > 0 && fires - f0 >= bp_at;
        bus.pool_ready = !hold_rdy;
        if (hold_rdy) begin
            bp_left--;
            if (bp_left == 0) check("bp_rd_stall", bus.fifo_rd_en, 0);
        end
        if (prev_v && !prev_r) begin
            check("bp_valid_hold", bus.pool_valid, 1);
            check("bp_data_stable", bus.pool_data, prev_d);
        end
        prev_v = bus.pool_valid;
        prev_r = bus.pool_ready;
        prev_d = bus.pool_data;
        if (bus.fifo_rd_en) check("rd_en_state", busy && !done, 1);
        if (bus.pool_valid && first_v < 0) first_v = cyc;
        if (bus.pool_valid && bus.pool_ready) begin
            last_pop = cyc;
            if (sb.size() == 0) check("extra_output", $signed(bus.pool_data), 32'sd99999);
            else check("pool_data", $signed(bus.pool_data), sb.pop_front());
        end
        if (bus.fifo_rd_en && !bus.fifo_empty) begin
            pend = src.pop_front();
            pend_v = 1'b1;
            fires++;
            if (fires - f0 == IMG_W + 2) fire_w1 = cyc;
            run++;
            if (run > max_run) max_run = run;
        end else run = 0;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (dup_pending && fires - f0 == 3) begin
            start_next = 1'b1;
            dup_pending = 1'b0;
        end
    endtask

    task automatic run_plane(input vec_t v);
        int d0 = done_cnt;
        src.delete();
        sb.delete();
        for (int i = 0; i < NPX; i++) src.push_back($signed(v.px[i]));
        for (int i = 0; i < NOUT; i++) sb.push_back(relu($signed(v.ex[i])));
        starve = v.starve;
        dup_pending = v.dup;
        bp_left = v.bp ? 20 : 0;
        f0 = fires;
        first_v = -1;
        fire_w1 = -1;
        max_run = 0;
        run = 0;
        prev_v = 1'b0;
        start_next = 1'b1;
        for (int k = 0; k < 2000 && done_cnt == d0; k++) tick();
        check("done_seen", done_cnt - d0, 1);
        check("rd_fires", fires - f0, NPX);
        check("outputs_left", sb.size(), 0);
        check("done_after_pop", done_cyc - last_pop, 1);
        repeat (4) tick();
        check("single_done", done_cnt - d0, 1);
        check("idle_after_done", busy, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, bus.fifo_rd_en, 0);
        check({tag, "_valid"}, bus.pool_valid, 0);
        check({tag, "_data"}, bus.pool_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start_next = 1'b0;
        pend_v = 1'b0;
        pend = '0;
        prev_v = 1'b0;
        prev_r = 1'b1;
        prev_d = '0;
        starve = 1'b0;
        dup_pending = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data = '0;
        bus.pool_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;

        tbl[0] = mk(nom, nom_e, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(nom, nom_e, 1'b1, 1'b0, 1'b1);
        tbl[2] = mk(nom, nom_e, 1'b0, 1'b1, 1'b0);
        tbl[3] = mk(tie, tie_e, 1'b0, 1'b0, 1'b0);
        tbl[4] = mk(ext, ext_e, 1'b1, 1'b1, 1'b0);

        run_plane(tbl[0]);
        check("burst_reads", max_run, NPX);
        check("first_valid_latency", first_v - fire_w1, 3);
        for (int t = 1; t < 5; t++) run_plane(tbl[t]);

        // Abandon a plane after 7 reads, then a fresh plane must pool correctly.
        src.delete();
        sb.delete();
        starve = 1'b0;
        bp_left = 0;
        f0 = fires;
        for (int i = 0; i < NPX; i++) src.push_back(DW'(nom[i]));
        start_next = 1'b1;
        for (int k = 0; k < 200 && fires - f0 < 7; k++) tick();
        check("reads_before_rst", fires - f0, 7);
        #2 rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        src.delete();
        pend_v = 1'b0;
        prev_v = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_plane(tbl[4]);

        for (int i = 0; i < NPX; i++) rp[i] = int'($urandom_range(0, 65535)) - 32768;
        for (int k = 0; k < NOUT; k++) re[k] = pool_ref(rp, k);
        run_plane(mk(rp, re, 1'b1, 1'b1, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
